// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use interlock, branch flush, memory-wait freeze,
// memory timeout detection and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned TIMEOUT  = 64,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  instr_id,
    input  logic [XLEN-1:0]  instr_ex,
    input  logic             uses_rs1_id,
    input  logic             uses_rs2_id,
    input  logic [1:0]       wb_sel_ex,
    input  logic             reg_wr_en_ex,
    input  logic             mispredict_ex,
    input  logic             dmem_req_mem,
    input  logic             dmem_ready,
    input  logic             perf_clr,
    output logic             pc_write,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             pipe_freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count
);

    localparam int unsigned   TW      = $clog2(TIMEOUT + 1);
    localparam logic [3:0]    LuInit  = 4'(LOAD_LAT - 1);
    localparam logic [TW-1:0] TmrMax  = TW'(TIMEOUT);
    localparam logic [TW-1:0] TmrLast = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StRun, StLuStall, StMemWait} state_e;

    state_e           state_q, state_d, state_eff;
    logic [3:0]       lu_cnt_q, lu_cnt_d, lu_cnt_eff;
    logic [TW-1:0]    timer_q, timer_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic       freeze;
    logic       lu_hit;
    logic       lu_step;
    logic [4:0] rd_ex;
    logic [4:0] rs1_id;
    logic [4:0] rs2_id;
    logic       unused_instr;

    assign rd_ex  = instr_ex[11:7];
    assign rs1_id = instr_id[19:15];
    assign rs2_id = instr_id[24:20];
    assign unused_instr = ^{instr_id[XLEN-1:25], instr_id[14:0],
                            instr_ex[XLEN-1:12], instr_ex[6:0]};

    assign freeze = dmem_req_mem && !dmem_ready;
    assign lu_hit = (wb_sel_ex == 2'b00) && reg_wr_en_ex && (rd_ex != 5'd0) &&
                    ((uses_rs1_id && (rd_ex == rs1_id)) || (uses_rs2_id && (rd_ex == rs2_id)));

    // While reset is held the outputs must look like RUN regardless of stored state.
    assign state_eff  = rst_n ? state_q : StRun;
    assign lu_cnt_eff = rst_n ? lu_cnt_q : 4'd0;

    always_comb begin
        pc_write     = 1'b1;
        if_id_we     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_freeze  = 1'b0;
        state_d      = state_eff;
        lu_cnt_d     = lu_cnt_eff;
        // Leaving MEM_WAIT with a pending count resumes the load-use stall in the same cycle.
        lu_step      = (state_eff == StLuStall) ||
                       ((state_eff == StMemWait) && (lu_cnt_eff != 4'd0));

        if (freeze) begin
            pc_write    = 1'b0;
            if_id_we    = 1'b0;
            pipe_freeze = 1'b1;
            state_d     = StMemWait;
        end else if (mispredict_ex) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            lu_cnt_d     = 4'd0;
            state_d      = StRun;
        end else if (lu_step) begin
            pc_write     = 1'b0;
            if_id_we     = 1'b0;
            id_ex_bubble = 1'b1;
            if (lu_cnt_eff <= 4'd1) begin
                lu_cnt_d = 4'd0;
                state_d  = StRun;
            end else begin
                lu_cnt_d = lu_cnt_eff - 4'd1;
                state_d  = StLuStall;
            end
        end else if (lu_hit) begin
            pc_write     = 1'b0;
            if_id_we     = 1'b0;
            id_ex_bubble = 1'b1;
            if (LOAD_LAT > 1) begin
                lu_cnt_d = LuInit;
                state_d  = StLuStall;
            end else begin
                state_d  = StRun;
            end
        end else begin
            state_d = StRun;
        end
    end

    always_comb begin
        timer_d       = '0;
        mem_timeout_d = mem_timeout_q;
        if (freeze) begin
            timer_d = (timer_q == TmrMax) ? timer_q : timer_q + TW'(1);
            if (timer_q >= TmrLast) begin
                mem_timeout_d = 1'b1;
            end
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (perf_clr) begin
            stall_count_d = '0;
        end else if (!pc_write && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StRun;
            lu_cnt_q      <= 4'd0;
            timer_q       <= '0;
            mem_timeout_q <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            lu_cnt_q      <= lu_cnt_d;
            timer_q       <= timer_d;
            mem_timeout_q <= mem_timeout_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign mem_timeout = mem_timeout_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench: two controller instances (LOAD_LAT=1 and LOAD_LAT=3/TIMEOUT=4/CNT_W=4)
// share stimulus; a cycle model pushes expected outputs that are popped and compared.
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_id, instr_ex;
    logic        uses_rs1_id, uses_rs2_id;
    logic [1:0]  wb_sel_ex;
    logic        reg_wr_en_ex, mispredict_ex, dmem_req_mem, dmem_ready, perf_clr;

    logic        a_pcw, a_ifw, a_fl, a_bub, a_frz, a_to;
    logic [31:0] a_cnt;
    logic        b_pcw, b_ifw, b_fl, b_bub, b_frz, b_to;
    logic [3:0]  b_cnt;

    typedef struct packed {
        logic        pcw, ifw, fl, bub, frz, to;
        logic [31:0] cnt;
    } exp_t;

    exp_t            sb_q[$];
    int              n_vec = 0;
    int              n_err = 0;
    int              cyc_n = 0;
    int              m_rem[2];
    int              m_tmr[2];
    bit              m_to[2];
    longint unsigned m_cnt[2];

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.XLEN(32), .LOAD_LAT(1), .TIMEOUT(64), .CNT_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .instr_id(instr_id), .instr_ex(instr_ex),
        .uses_rs1_id(uses_rs1_id), .uses_rs2_id(uses_rs2_id), .wb_sel_ex(wb_sel_ex),
        .reg_wr_en_ex(reg_wr_en_ex), .mispredict_ex(mispredict_ex),
        .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready), .perf_clr(perf_clr),
        .pc_write(a_pcw), .if_id_we(a_ifw), .if_id_flush(a_fl), .id_ex_bubble(a_bub),
        .pipe_freeze(a_frz), .mem_timeout(a_to), .stall_count(a_cnt)
    );

    hazard_stall_ctrl #(.XLEN(32), .LOAD_LAT(3), .TIMEOUT(4), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .instr_id(instr_id), .instr_ex(instr_ex),
        .uses_rs1_id(uses_rs1_id), .uses_rs2_id(uses_rs2_id), .wb_sel_ex(wb_sel_ex),
        .reg_wr_en_ex(reg_wr_en_ex), .mispredict_ex(mispredict_ex),
        .dmem_req_mem(dmem_req_mem), .dmem_ready(dmem_ready), .perf_clr(perf_clr),
        .pc_write(b_pcw), .if_id_we(b_ifw), .if_id_flush(b_fl), .id_ex_bubble(b_bub),
        .pipe_freeze(b_frz), .mem_timeout(b_to), .stall_count(b_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc_n, got, exp);
        end
    endtask

    // Behavioural model: remaining load-use bubbles, freeze timer, sticky flag, counter.
    task automatic model(input int i, output exp_t e);
        logic            frz, lu;
        logic [4:0]      rd;
        int              rem;
        int              lat  = (i == 0) ? 1 : 3;
        int              tmo  = (i == 0) ? 64 : 4;
        longint unsigned cmax = (i == 0) ? 64'hFFFF_FFFF : 64'd15;
        rd  = instr_ex[11:7];
        frz = dmem_req_mem && !dmem_ready;
        lu  = (wb_sel_ex == 2'b00) && reg_wr_en_ex && (rd != 5'd0) &&
              ((uses_rs1_id && rd == instr_id[19:15]) || (uses_rs2_id && rd == instr_id[24:20]));
        rem = rst_n ? m_rem[i] : 0;
        e = '0;
        e.pcw = 1'b1;
        e.ifw = 1'b1;
        e.to  = m_to[i];
        e.cnt = 32'(m_cnt[i]);
        if (frz) begin
            e.pcw = 1'b0; e.ifw = 1'b0; e.frz = 1'b1;
        end else if (mispredict_ex) begin
            e.fl = 1'b1; e.bub = 1'b1; rem = 0;
        end else if (rem > 0) begin
            e.pcw = 1'b0; e.ifw = 1'b0; e.bub = 1'b1; rem--;
        end else if (lu) begin
            e.pcw = 1'b0; e.ifw = 1'b0; e.bub = 1'b1; rem = lat - 1;
        end
        if (!rst_n) begin
            m_rem[i] = 0; m_tmr[i] = 0; m_to[i] = 1'b0; m_cnt[i] = 0;
        end else begin
            m_rem[i] = rem;
            if (frz) begin
                if (m_tmr[i] + 1 >= tmo) m_to[i] = 1'b1;
                if (m_tmr[i] < tmo) m_tmr[i]++;
            end else begin
                m_tmr[i] = 0;
            end
            if (perf_clr) m_cnt[i] = 0;
            else if (!e.pcw && m_cnt[i] < cmax) m_cnt[i]++;
        end
    endtask

    task automatic compare_one(input string p, input exp_t e, input exp_t got);
        check_eq({p, "pc_write"},     {31'd0, got.pcw}, {31'd0, e.pcw});
        check_eq({p, "if_id_we"},     {31'd0, got.ifw}, {31'd0, e.ifw});
        check_eq({p, "if_id_flush"},  {31'd0, got.fl},  {31'd0, e.fl});
        check_eq({p, "id_ex_bubble"}, {31'd0, got.bub}, {31'd0, e.bub});
        check_eq({p, "pipe_freeze"},  {31'd0, got.frz}, {31'd0, e.frz});
        check_eq({p, "mem_timeout"},  {31'd0, got.to},  {31'd0, e.to});
        check_eq({p, "stall_count"},  got.cnt,          e.cnt);
    endtask

    // Inputs already set at the falling edge; push, settle, pop and compare, next falling edge.
    task automatic step();
        exp_t e, got;
        model(0, e); sb_q.push_back(e);
        model(1, e); sb_q.push_back(e);
        #2;
        for (int i = 0; i < 2; i++) begin
            if (sb_q.size() == 0) begin
                check_eq("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                if (i == 0) got = {a_pcw, a_ifw, a_fl, a_bub, a_frz, a_to, a_cnt};
                else        got = {b_pcw, b_ifw, b_fl, b_bub, b_frz, b_to, 28'd0, b_cnt};
                compare_one((i == 0) ? "a_" : "b_", e, got);
            end
        end
        cyc_n++;
        @(negedge clk);
    endtask

    task automatic cyc(input bit rst, input bit mis, input bit req, input bit rdy, input bit clr,
                       input bit ld, input int rd, input int rs1, input int rs2,
                       input bit u1, input bit u2);
        rst_n         = ~rst;
        mispredict_ex = mis;
        dmem_req_mem  = req;
        dmem_ready    = rdy;
        perf_clr      = clr;
        wb_sel_ex     = ld ? 2'b00 : 2'b01;
        reg_wr_en_ex  = 1'b1;
        instr_ex      = 32'(rd) << 7;
        instr_id      = (32'(rs2) << 20) | (32'(rs1) << 15);
        uses_rs1_id   = u1;
        uses_rs2_id   = u2;
        step();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0; mispredict_ex = 1'b0; dmem_req_mem = 1'b0; dmem_ready = 1'b1;
        perf_clr = 1'b0; wb_sel_ex = 2'b01; reg_wr_en_ex = 1'b0; instr_ex = '0; instr_id = '0;
        uses_rs1_id = 1'b0; uses_rs2_id = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_rem[i] = 0; m_tmr[i] = 0; m_to[i] = 1'b0; m_cnt[i] = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);

        cyc(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // lw x5 in EX, add x6,x5,x1 in ID
        cyc(0, 0, 0, 1, 0, 1, 5, 5, 1, 1, 1);
        idle(4);
        cyc(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        // rd = x0, unused rs2 match, used rs2 match, non-load producer
        cyc(0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 1);
        cyc(0, 0, 0, 1, 0, 1, 7, 3, 7, 1, 0);
        cyc(0, 0, 0, 1, 0, 1, 7, 3, 7, 1, 1);
        idle(3);
        cyc(0, 0, 0, 1, 0, 0, 5, 5, 1, 1, 1);
        // mispredict together with a load-use hit
        cyc(0, 1, 0, 1, 0, 1, 5, 5, 1, 1, 1);
        idle(2);
        // two freeze cycles inside the load-use stall
        cyc(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 1, 5, 5, 1, 1, 1);
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(4);
        // reset in the middle of a stall
        cyc(0, 0, 0, 1, 0, 1, 5, 5, 1, 1, 1);
        cyc(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        // held memory wait to trigger the sticky timeout
        for (int k = 0; k < 6; k++) cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        cyc(0, 0, 1, 1, 0, 1, 5, 5, 1, 1, 1);
        idle(3);
        cyc(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        for (int k = 0; k < 400; k++) begin
            rst_n         = ($urandom_range(63) != 0);
            mispredict_ex = ($urandom_range(15) == 0);
            dmem_req_mem  = ($urandom_range(2) == 0);
            dmem_ready    = ($urandom_range(1) == 0);
            perf_clr      = ($urandom_range(47) == 0);
            wb_sel_ex     = 2'($urandom_range(3));
            reg_wr_en_ex  = ($urandom_range(3) != 0);
            instr_ex      = 32'($urandom) & ~(32'h1F << 7) | (32'($urandom_range(3)) << 7);
            instr_id      = (32'($urandom) & ~(32'h3FF << 15)) |
                            (32'($urandom_range(3)) << 20) | (32'($urandom_range(3)) << 15);
            uses_rs1_id   = 1'($urandom_range(1));
            uses_rs2_id   = 1'($urandom_range(1));
            step();
        end
        cyc(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 Parameter XLEN, default 32, instruction width.
REQ-002 Parameter LOAD_LAT, default 1, load-use stall cycles (1..8); 1 gives the classic single bubble.
REQ-003 Parameter TIMEOUT, default 64, max consecutive memory-wait cycles before error.
REQ-004 Parameter CNT_W, default 32, width of the stall performance counter.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  synchronous, active-low reset.
REQ-007 instr_id  input  XLEN  instruction in ID; rs1=[19:15], rs2=[24:20].
REQ-008 instr_ex  input  XLEN  instruction in EX; rd=[11:7].
REQ-009 uses_rs1_id, uses_rs2_id  input  1 each  ID instruction reads rs1/rs2.
REQ-010 wb_sel_ex  input  2  EX writeback select; 2'b00 = load data.
REQ-011 reg_wr_en_ex  input  1  EX instruction writes rd.
REQ-012 mispredict_ex  input  1  EX branch resolved mispredicted.
REQ-013 dmem_req_mem  input  1  MEM-stage memory access active.
REQ-014 dmem_ready  input  1  data memory completes the access this cycle.
REQ-015 perf_clr  input  1  synchronous clear of stall_count.
REQ-016 pc_write  output  1  PC update enable.
REQ-017 if_id_we  output  1  IF/ID register write enable.
REQ-018 if_id_flush  output  1  IF/ID cleared to NOP.
REQ-019 id_ex_bubble  output  1  ID/EX loaded with zero control (stall mux select).
REQ-020 pipe_freeze  output  1  hold ID/EX, EX/MEM, MEM/WB.
REQ-021 mem_timeout  output  1  sticky error flag.
REQ-022 stall_count  output  CNT_W  saturating count of stall cycles.

Function
REQ-023 Load-use hazard (lu_hit) SHALL be: wb_sel_ex==0 && reg_wr_en_ex && rd!=0 && ((uses_rs1_id && rd==rs1) || (uses_rs2_id && rd==rs2)).
REQ-024 FSM states SHALL be RUN, LU_STALL, MEM_WAIT; reset state RUN.
REQ-025 Priority SHALL be freeze > mispredict > load-use stall.
REQ-026 Freeze condition SHALL be dmem_req_mem && !dmem_ready, applied combinationally in any state: pc_write=0, if_id_we=0, pipe_freeze=1, id_ex_bubble=0, if_id_flush=0.
REQ-027 Freeze SHALL move the FSM to MEM_WAIT and preserve the LU stall counter; when freeze drops, the FSM SHALL return to LU_STALL if the counter is nonzero, otherwise to RUN.
REQ-028 The MEM_WAIT timer SHALL count consecutive freeze cycles and set mem_timeout when it reaches TIMEOUT; mem_timeout SHALL clear only on reset.
REQ-029 Without freeze, mispredict_ex SHALL give if_id_flush=1, id_ex_bubble=1, pc_write=1, if_id_we=1, clear the LU counter and force RUN; lu_hit is ignored that cycle.
REQ-030 In RUN with lu_hit and no freeze or mispredict: pc_write=0, if_id_we=0, id_ex_bubble=1 the same cycle (zero-latency detect).
REQ-031 If LOAD_LAT>1, that cycle SHALL also load the counter with LOAD_LAT-1 and enter LU_STALL.
REQ-032 LU_STALL SHALL hold the REQ-030 outputs without re-evaluating lu_hit, decrementing the counter each non-frozen cycle; on the cycle the counter is 1 it SHALL go to RUN.
REQ-033 Total load-use stall SHALL be exactly LOAD_LAT cycles, excluding freeze cycles.
REQ-034 Idle outputs (RUN, no event) SHALL be pc_write=1, if_id_we=1, all others 0.
REQ-035 stall_count SHALL increment on every cycle with pc_write==0, saturate at all-ones, and zero on perf_clr; perf_clr has priority over increment.

Reset
REQ-036 With rst_n low at a clock edge: FSM=RUN, LU counter=0, timer=0, mem_timeout=0, stall_count=0.
REQ-037 During reset, outputs SHALL follow the RUN equations from their inputs.
REQ-038 Reset mid-stall SHALL abandon the stall; the next cycle is RUN.

Verification
REQ-039 LOAD_LAT=1: EX lw x5, ID add x6,x5,x1 -> one cycle pc_write=0, id_ex_bubble=1; stall_count=1.
REQ-040 LOAD_LAT=3: same pair -> three consecutive stall cycles, then RUN; stall_count=3.
REQ-041 EX lw x0, ID reads x0; or ID uses_rs2_id=0 with rd==rs2 -> no stall.
REQ-042 LOAD_LAT=3: dmem_ready=0 for 2 cycles inserted mid-LU_STALL -> pipe_freeze=1 for 2 cycles, then 2 remaining LU cycles; stall_count=5.
REQ-043 mispredict_ex together with lu_hit -> if_id_flush=1, id_ex_bubble=1, pc_write=1, no stall next cycle.
REQ-044 TIMEOUT=4, dmem_ready held 0 -> mem_timeout=1 after the 4th freeze cycle, held until rst_n=0.
